// File: rtl/articolor_testgen_if.sv
// ============================================================================
//  Module      : articolor_testgen_if
//  Description : Pattern-control inputs and video outputs of articolor_testgen.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface articolor_testgen_if;
    logic       ce_pix;
    logic [1:0] mode;
    logic [7:0] level;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;
    logic       hbl_out;
    logic       vbl_out;
    logic       hs_out;
    logic       vs_out;
    logic [7:0] frame_cnt;

    // master = the pattern generator, slave = whatever consumes the video
    modport master (
        input  ce_pix, mode, level,
        output r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out, frame_cnt
    );
    modport slave (
        output ce_pix, mode, level,
        input  r_out, g_out, b_out, hbl_out, vbl_out, hs_out, vs_out, frame_cnt
    );
endinterface

`default_nettype wire

// File: rtl/articolor_testgen.sv
// ============================================================================
//  Module      : articolor_testgen
//  Description : Pixel-rate stripe/ramp pattern source with blank and sync
//                timing. Optional macro ARTICOLOR_TESTGEN_LINEFLIP_EN swaps
//                the 1-px stripe phase on odd lines.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module articolor_testgen #(
    parameter int H_TOTAL  = 456,
    parameter int H_ACTIVE = 384,
    parameter int HS_START = 400,
    parameter int HS_LEN   = 32,
    parameter int V_TOTAL  = 312,
    parameter int V_ACTIVE = 240,
    parameter int VS_START = 270,
    parameter int VS_LEN   = 3
) (
    input wire clk,
    input wire reset_n,
    articolor_testgen_if.master vid
);

    // Horizontal counter is at least 8 bits so the ramp can use hcnt[7:0].
    localparam int C_HW = ($clog2(H_TOTAL + 1) > 8) ? $clog2(H_TOTAL + 1) : 8;
    localparam int C_VW = $clog2(V_TOTAL + 1);

    localparam logic [C_HW-1:0] C_H_LAST   = C_HW'(H_TOTAL - 1);
    localparam logic [C_HW-1:0] C_H_ACTIVE = C_HW'(H_ACTIVE);
    localparam logic [C_HW-1:0] C_HS_START = C_HW'(HS_START);
    localparam logic [C_HW-1:0] C_HS_END   = C_HW'(HS_START + HS_LEN);
    localparam logic [C_VW-1:0] C_V_LAST   = C_VW'(V_TOTAL - 1);
    localparam logic [C_VW-1:0] C_V_ACTIVE = C_VW'(V_ACTIVE);
    localparam logic [C_VW-1:0] C_VS_START = C_VW'(VS_START);
    localparam logic [C_VW-1:0] C_VS_END   = C_VW'(VS_START + VS_LEN);

    generate
        if ((H_ACTIVE >= H_TOTAL) || (HS_START + HS_LEN > H_TOTAL) ||
            (V_ACTIVE >= V_TOTAL) || (VS_START + VS_LEN > V_TOTAL)) begin : g_bad_params
            $error("articolor_testgen: illegal timing parameters");
        end
    endgenerate

    logic [C_HW-1:0] r_hcnt;
    logic [C_VW-1:0] r_vcnt;
    logic [7:0]      r_frame_cnt;
    logic [1:0]      r_mode_q;
    logic [7:0]      r_level_q;
    logic [7:0]      r_y;
    logic            r_hbl;
    logic            r_vbl;
    logic            r_hs;
    logic            r_vs;

    logic            w_frame_start;
    logic [1:0]      w_mode;
    logic [7:0]      w_level;
    logic            w_hbl;
    logic            w_vbl;
    logic            w_hs;
    logic            w_vs;
    logic            w_flip;
    logic [7:0]      w_y;

    // The first pixel of a frame already uses the freshly sampled mode/level.
    assign w_frame_start = (r_hcnt == '0) && (r_vcnt == '0);
    assign w_mode        = w_frame_start ? vid.mode  : r_mode_q;
    assign w_level       = w_frame_start ? vid.level : r_level_q;

    assign w_hbl = (r_hcnt >= C_H_ACTIVE);
    assign w_vbl = (r_vcnt >= C_V_ACTIVE);
    assign w_hs  = (r_hcnt >= C_HS_START) && (r_hcnt < C_HS_END);
    assign w_vs  = (r_vcnt >= C_VS_START) && (r_vcnt < C_VS_END);

`ifdef ARTICOLOR_TESTGEN_LINEFLIP_EN
    assign w_flip = r_vcnt[0];
`else
    assign w_flip = 1'b0;
`endif

    always_comb begin
        w_y = '0;
        case (w_mode)
            2'd0:    if (r_hcnt[0] == w_flip) w_y = w_level;
            2'd1:    if (r_hcnt[0] != w_flip) w_y = w_level;
            2'd2:    if (!r_hcnt[1])          w_y = w_level;
            default: w_y = r_hcnt[7:0];
        endcase
        if (w_hbl || w_vbl) begin
            w_y = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_frame_cnt <= '0;
            r_mode_q    <= '0;
            r_level_q   <= '0;
            r_y         <= '0;
            r_hbl       <= 1'b1;
            r_vbl       <= 1'b1;
            r_hs        <= 1'b0;
            r_vs        <= 1'b0;
        end else if (vid.ce_pix) begin
            if (r_hcnt == C_H_LAST) begin
                r_hcnt <= '0;
                if (r_vcnt == C_V_LAST) begin
                    r_vcnt      <= '0;
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end else begin
                    r_vcnt <= r_vcnt + C_VW'(1);
                end
            end else begin
                r_hcnt <= r_hcnt + C_HW'(1);
            end

            if (w_frame_start) begin
                r_mode_q  <= vid.mode;
                r_level_q <= vid.level;
            end

            r_y   <= w_y;
            r_hbl <= w_hbl;
            r_vbl <= w_vbl;
            r_hs  <= w_hs;
            r_vs  <= w_vs;
        end
    end

    assign vid.r_out     = r_y;
    assign vid.g_out     = r_y;
    assign vid.b_out     = r_y;
    assign vid.hbl_out   = r_hbl;
    assign vid.vbl_out   = r_vbl;
    assign vid.hs_out    = r_hs;
    assign vid.vs_out    = r_vs;
    assign vid.frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_articolor_testgen.sv
// ============================================================================
//  Module      : tb_articolor_testgen
//  Description : Self-checking bench for articolor_testgen on a small raster.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_articolor_testgen;

    localparam int H_TOTAL  = 16;
    localparam int H_ACTIVE = 10;
    localparam int HS_START = 12;
    localparam int HS_LEN   = 2;
    localparam int V_TOTAL  = 6;
    localparam int V_ACTIVE = 4;
    localparam int VS_START = 5;
    localparam int VS_LEN   = 1;
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    localparam logic [35:0] RST_EXP = {24'h0, 4'b1100, 8'h00};

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    articolor_testgen_if vif();

    articolor_testgen #(
        .H_TOTAL (H_TOTAL),
        .H_ACTIVE(H_ACTIVE),
        .HS_START(HS_START),
        .HS_LEN  (HS_LEN),
        .V_TOTAL (V_TOTAL),
        .V_ACTIVE(V_ACTIVE),
        .VS_START(VS_START),
        .VS_LEN  (VS_LEN)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .vid    (vif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: pixel index since reset plus the frame-start latch.
    int          m_n;
    logic [1:0]  m_mode;
    logic [7:0]  m_level;
    logic [35:0] m_exp;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [7:0] level;
        int         h;
        int         v;
        logic [7:0] y;
        logic [3:0] flags;  // {hbl, vbl, hs, vs}
    } vec_t;

    vec_t vecs[18];

    function automatic logic [35:0] pack_out();
        return {vif.r_out, vif.g_out, vif.b_out,
                vif.hbl_out, vif.vbl_out, vif.hs_out, vif.vs_out, vif.frame_cnt};
    endfunction

    function automatic logic [35:0] expect_px(input int n, input logic [1:0] md,
                                               input logic [7:0] lv);
        int         p;
        int         h;
        int         v;
        int         flip;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
        logic [7:0] y;
        logic [7:0] fr;
        p  = n % FRAME;
        h  = p % H_TOTAL;
        v  = p / H_TOTAL;
        hb = (h >= H_ACTIVE);
        vb = (v >= V_ACTIVE);
        hs = (h >= HS_START) && (h < HS_START + HS_LEN);
        vs = (v >= VS_START) && (v < VS_START + VS_LEN);
`ifdef ARTICOLOR_TESTGEN_LINEFLIP_EN
        flip = v % 2;
`else
        flip = 0;
`endif
        case (md)
            2'd0:    y = ((h % 2) == flip) ? lv : 8'd0;
            2'd1:    y = ((h % 2) != flip) ? lv : 8'd0;
            2'd2:    y = (((h / 2) % 2) == 0) ? lv : 8'd0;
            default: y = 8'(h % 256);
        endcase
        if (hb || vb) y = 8'd0;
        fr = 8'(((n + 1) / FRAME) % 256);
        return {y, y, y, hb, vb, hs, vs, fr};
    endfunction

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic ce);
        vif.ce_pix = ce;
        if (ce) begin
            if (m_n % FRAME == 0) begin
                m_mode  = vif.mode;
                m_level = vif.level;
            end
            m_exp = expect_px(m_n, m_mode, m_level);
            m_n++;
        end
        @(posedge clk);
        #1;
        check("model", pack_out(), m_exp);
    endtask

    // Reset lands between clock edges and must take effect without a clock.
    task automatic do_reset();
        vif.ce_pix = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_async", pack_out(), RST_EXP);
        @(posedge clk);
        #1;
        check("reset_hold", pack_out(), RST_EXP);
        reset_n = 1'b1;
        m_n     = 0;
        m_mode  = 2'd0;
        m_level = 8'd0;
        m_exp   = RST_EXP;
    endtask

    task automatic run_to(input int target);
        while (m_n < target) cycle(1'b1);
    endtask

    initial begin
        vif.ce_pix = 1'b0;
        vif.mode   = 2'd0;
        vif.level  = 8'd0;
        m_n = 0; m_mode = 2'd0; m_level = 8'd0; m_exp = RST_EXP;

        vecs[0]  = '{"m0_px0",   2'd0, 8'd200, 0,  0, 8'd200, 4'b0000};
        vecs[1]  = '{"m0_px1",   2'd0, 8'd200, 1,  0, 8'd0,   4'b0000};
        vecs[2]  = '{"m0_px8",   2'd0, 8'd200, 8,  2, 8'd200, 4'b0000};
        vecs[3]  = '{"m0_hbl10", 2'd0, 8'd200, 10, 0, 8'd0,   4'b1000};
        vecs[4]  = '{"m0_hbl15", 2'd0, 8'd200, 15, 0, 8'd0,   4'b1000};
        vecs[5]  = '{"m0_hs12",  2'd0, 8'd200, 12, 1, 8'd0,   4'b1010};
        vecs[6]  = '{"m0_hs13",  2'd0, 8'd200, 13, 1, 8'd0,   4'b1010};
        vecs[7]  = '{"m0_hs14",  2'd0, 8'd200, 14, 1, 8'd0,   4'b1000};
        vecs[8]  = '{"m0_vbl4",  2'd0, 8'd200, 0,  4, 8'd0,   4'b0100};
        vecs[9]  = '{"m0_vs5",   2'd0, 8'd200, 3,  5, 8'd0,   4'b0101};
        vecs[10] = '{"m1_px0",   2'd1, 8'd200, 0,  0, 8'd0,   4'b0000};
        vecs[11] = '{"m1_px1",   2'd1, 8'd200, 1,  0, 8'd200, 4'b0000};
        vecs[12] = '{"m2_px1",   2'd2, 8'd200, 1,  0, 8'd200, 4'b0000};
        vecs[13] = '{"m2_px2",   2'd2, 8'd200, 2,  0, 8'd0,   4'b0000};
        vecs[14] = '{"m2_px4",   2'd2, 8'd200, 4,  3, 8'd200, 4'b0000};
        vecs[15] = '{"m3_px9",   2'd3, 8'd200, 9,  3, 8'd9,   4'b0000};
`ifdef ARTICOLOR_TESTGEN_LINEFLIP_EN
        vecs[16] = '{"m0_l1_px0", 2'd0, 8'd200, 0, 1, 8'd0,   4'b0000};
        vecs[17] = '{"m0_l1_px1", 2'd0, 8'd200, 1, 1, 8'd200, 4'b0000};
`else
        vecs[16] = '{"m0_l1_px0", 2'd0, 8'd200, 0, 1, 8'd200, 4'b0000};
        vecs[17] = '{"m0_l1_px1", 2'd0, 8'd200, 1, 1, 8'd0,   4'b0000};
`endif

        @(posedge clk);
        #1;
        check("reset_init", pack_out(), RST_EXP);

        foreach (vecs[i]) begin
            do_reset();
            vif.mode  = vecs[i].mode;
            vif.level = vecs[i].level;
            run_to(vecs[i].v * H_TOTAL + vecs[i].h + 1);
            check({vecs[i].name, "_rgb"}, {12'h0, vif.r_out, vif.g_out, vif.b_out},
                  {12'h0, vecs[i].y, vecs[i].y, vecs[i].y});
            check({vecs[i].name, "_flags"},
                  {32'h0, vif.hbl_out, vif.vbl_out, vif.hs_out, vif.vs_out},
                  {32'h0, vecs[i].flags});
        end

        // Mode change mid-frame only takes effect at the next frame start.
        do_reset();
        vif.mode  = 2'd0;
        vif.level = 8'd200;
        run_to(2 * H_TOTAL);
        vif.mode = 2'd3;
        run_to(3 * H_TOTAL + 2 + 1);
        check("midframe_hold", {28'h0, vif.r_out}, {28'h0, 8'd200});
        run_to(FRAME + 1 * H_TOTAL + 7 + 1);
        check("ramp_next", {28'h0, vif.r_out}, {28'h0, 8'd7});

        // Pixel enable on every other clock; holds are checked by the model.
        do_reset();
        vif.mode  = 2'd0;
        vif.level = 8'd200;
        for (int i = 0; i < 60; i++) cycle(i[0] == 1'b0);
        run_to(m_n + 5);
        do_reset();

        // Random enables, patterns and mid-line resets.
        for (int k = 0; k < 4; k++) begin
            vif.mode  = 2'($urandom);
            vif.level = 8'($urandom);
            for (int i = 0; i < 2 * FRAME + 40; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    vif.mode  = 2'($urandom);
                    vif.level = 8'($urandom);
                end
                cycle($urandom_range(0, 3) != 0);
            end
            do_reset();
        end

        // frame_cnt wraps after 256 frames.
        vif.mode  = 2'd3;
        vif.level = 8'd0;
        run_to(FRAME);
        check("frame_one", {28'h0, vif.frame_cnt}, {28'h0, 8'd1});
        run_to(256 * FRAME);
        check("frame_wrap", {28'h0, vif.frame_cnt}, {28'h0, 8'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
